// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank: per-pin output/output-enable, atomic set/clear,
// synchronised inputs with rise/fall detection and W1C status folded onto 3 IRQ lines.
module wb_gpio_bank #(
    parameter int          N_PINS      = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oeb,
    output logic [2:0]        irq
);

    localparam logic [2:0] REG_OUT     = 3'd0;
    localparam logic [2:0] REG_OE      = 3'd1;
    localparam logic [2:0] REG_IN      = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;
    localparam logic [2:0] REG_STAT    = 3'd5;
    localparam logic [2:0] REG_OUT_SET = 3'd6;
    localparam logic [2:0] REG_OUT_CLR = 3'd7;

    function automatic logic [N_PINS-1:0] lane_mask(input int lane);
        logic [N_PINS-1:0] m;
        m = '0;
        for (int i = 0; i < N_PINS; i++) m[i] = ((i % 3) == lane);
        return m;
    endfunction

    logic              ack_reg;
    logic [31:0]       dat_reg;
    logic [N_PINS-1:0] out_reg, oe_reg, rise_en_reg, fall_en_reg, stat_reg, prev_reg;
    logic [N_PINS-1:0] sync_reg [SYNC_STAGES];
    logic [N_PINS-1:0] in_sync;

    logic              access, mapped, wr;
    logic [2:0]        reg_sel;
    logic [31:0]       byte_mask;
    logic [N_PINS-1:0] wr_mask, wr_bits, stat_clr, events, rd_pins;
    logic [31:0]       rd_word;
    logic              unused_bits;

    // Input synchroniser chain; IN is the last stage.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                    if (wb_rst_i) sync_reg[gi] <= '0;
                    else          sync_reg[gi] <= gpio_in;
                end
            end else begin : g_next
                always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                    if (wb_rst_i) sync_reg[gi] <= '0;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign byte_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
        end

        for (genvar gi = 0; gi < 3; gi++) begin : g_irq
            assign irq[gi] = |(stat_reg & lane_mask(gi));
        end
    endgenerate

    assign in_sync = sync_reg[SYNC_STAGES-1];

    // The !ack term keeps a held strobe from re-selecting in the ack cycle.
    assign access  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_reg;
    assign mapped  = (wbs_adr_i[7:5] == 3'd0);
    assign reg_sel = wbs_adr_i[4:2];
    assign wr      = access & wbs_we_i & mapped;
    assign wr_mask = byte_mask[N_PINS-1:0];
    assign wr_bits = wbs_dat_i[N_PINS-1:0] & wr_mask;

    assign events   = (in_sync & ~prev_reg & rise_en_reg) | (~in_sync & prev_reg & fall_en_reg);
    assign stat_clr = (wr && reg_sel == REG_STAT) ? wr_bits : '0;

    always_comb begin
        rd_pins = '0;
        if (mapped) begin
            case (reg_sel)
                REG_OUT:     rd_pins = out_reg;
                REG_OE:      rd_pins = oe_reg;
                REG_IN:      rd_pins = in_sync;
                REG_RISE_EN: rd_pins = rise_en_reg;
                REG_FALL_EN: rd_pins = fall_en_reg;
                REG_STAT:    rd_pins = stat_reg;
                default:     rd_pins = '0;
            endcase
        end
        rd_word = '0;
        rd_word[N_PINS-1:0] = rd_pins;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
            out_reg     <= '0;
            oe_reg      <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            stat_reg    <= '0;
            prev_reg    <= '0;
        end else begin
            ack_reg  <= access;
            dat_reg  <= (access && !wbs_we_i) ? rd_word : 32'd0;
            prev_reg <= in_sync;
            // New events are OR-ed in after the clear so a colliding event survives.
            stat_reg <= (stat_reg & ~stat_clr) | events;
            if (wr) begin
                case (reg_sel)
                    REG_OUT:     out_reg     <= (out_reg & ~wr_mask) | wr_bits;
                    REG_OE:      oe_reg      <= (oe_reg & ~wr_mask) | wr_bits;
                    REG_RISE_EN: rise_en_reg <= (rise_en_reg & ~wr_mask) | wr_bits;
                    REG_FALL_EN: fall_en_reg <= (fall_en_reg & ~wr_mask) | wr_bits;
                    REG_OUT_SET: out_reg     <= out_reg | wr_bits;
                    REG_OUT_CLR: out_reg     <= out_reg & ~wr_bits;
                    default:     ;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign gpio_out  = out_reg;
    assign gpio_oeb  = ~oe_reg;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, byte_mask};

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Self-checking bench for wb_gpio_bank: directed register/edge scenarios plus
// randomized register and pin traffic checked against a behavioural register model.
module tb_wb_gpio_bank;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_w;
    logic          ack;
    logic [31:0]   dat_r;
    logic [N-1:0]  gpio_in, gpio_out, gpio_oeb;
    logic [2:0]    irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] m_out, m_oe, m_rise, m_fall, m_stat, m_pins;

    wb_gpio_bank #(.N_PINS(N), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_r),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oeb (gpio_oeb),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        logic [N-1:0] b, v;
        if (a[31:8] != BASE[31:8] || a[7:5] != 3'd0) return;
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        b  = bm[N-1:0];
        v  = d[N-1:0] & b;
        case (a[4:2])
            3'd0: m_out  = (m_out & ~b) | v;
            3'd1: m_oe   = (m_oe & ~b) | v;
            3'd3: m_rise = (m_rise & ~b) | v;
            3'd4: m_fall = (m_fall & ~b) | v;
            3'd5: m_stat = m_stat & ~v;
            3'd6: m_out  = m_out | v;
            3'd7: m_out  = m_out & ~v;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[7:5] == 3'd0) begin
            case (a[4:2])
                3'd0: r[N-1:0] = m_out;
                3'd1: r[N-1:0] = m_oe;
                3'd2: r[N-1:0] = m_pins;
                3'd3: r[N-1:0] = m_rise;
                3'd4: r[N-1:0] = m_fall;
                3'd5: r[N-1:0] = m_stat;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [2:0] model_irq();
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (m_stat[i]) r[i % 3] = 1'b1;
        return r;
    endfunction

    // ---------------- bus access (called and returns at a negedge) ----------------
    task automatic bus_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] rdata, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        lat = 0; rdata = '0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = c; rdata = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_checks++;
        if (lat == 0) begin
            n_fail++;
            $display("FAIL ack_timeout addr=%08h: no ack within 4 cycles, required one", a);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0 || dat_r !== 32'd0) begin
            n_fail++;
            $display("FAIL idle_bus addr=%08h: ack=%b dat=%08h, required ack=0 dat=0", a, ack, dat_r);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
        logic [31:0] dummy;
        bus_access(a, 1'b1, d, s, dummy, lat);
        model_write(a, d, s);
        $display("WR  addr=%08h data=%08h sel=%h lat=%0d", a, d, s, lat);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int lat;
        bus_access(a, 1'b0, 32'd0, 4'hF, d, lat);
        $display("RD  addr=%08h data=%08h lat=%0d", a, d, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] r;
        n_checks++;
        if (gpio_out !== '0 || gpio_oeb !== '1 || ack !== 1'b0 || dat_r !== 32'd0 || irq !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: out=%h oeb=%h ack=%b dat=%h irq=%b, required 0/ffff/0/0/0",
                     gpio_out, gpio_oeb, ack, dat_r, irq);
        end
        for (int o = 0; o < 8; o++) begin
            wb_read(BASE + 32'(o * 4), r);
            n_checks++;
            if (r !== model_read(BASE + 32'(o * 4))) begin
                n_fail++;
                $display("FAIL reset_read off=%0d: got %08h, required %08h", o * 4, r, model_read(BASE + 32'(o * 4)));
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] r;
        wb_write(BASE + 32'h04, 32'h0000_00FF, 4'hF, lat);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL ack_latency: got %0d cycles, required 1", lat);
        end
        wb_write(BASE + 32'h00, 32'h0000_00A5, 4'hF, lat);
        n_checks++;
        if (gpio_oeb !== 16'hFF00 || gpio_out !== 16'h00A5) begin
            n_fail++;
            $display("FAIL basic_pads: oeb=%h out=%h, required ff00 00a5", gpio_oeb, gpio_out);
        end
        wb_read(BASE + 32'h04, r);
        n_checks++;
        if (r !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL basic_oe_read: got %08h, required 000000ff", r);
        end
        wb_read(BASE + 32'h00, r);
        n_checks++;
        if (r !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL basic_out_read: got %08h, required 000000a5", r);
        end
    endtask

    task automatic test_set_clr();
        int lat;
        logic [31:0] r;
        wb_write(BASE + 32'h00, 32'h0000_00F0, 4'hF, lat);
        wb_write(BASE + 32'h18, 32'h0000_0003, 4'hF, lat);
        wb_write(BASE + 32'h1C, 32'h0000_0030, 4'hF, lat);
        wb_read(BASE + 32'h00, r);
        n_checks++;
        if (r !== 32'h0000_00C3) begin
            n_fail++;
            $display("FAIL set_clr_out: got %08h, required 000000c3", r);
        end
        wb_read(BASE + 32'h1C, r);
        n_checks++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL out_clr_read: got %08h, required 0", r);
        end
        wb_read(BASE + 32'h18, r);
        n_checks++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL out_set_read: got %08h, required 0", r);
        end
    endtask

    task automatic test_byte_enable();
        int lat;
        int seen;
        logic [31:0] r;
        wb_write(BASE + 32'h00, 32'h0, 4'hF, lat);
        wb_write(BASE + 32'h00, 32'h0000_FFFF, 4'b0001, lat);
        wb_read(BASE + 32'h00, r);
        n_checks++;
        if (r !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL byte_enable: got %08h, required 000000ff", r);
        end
        wb_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, lat);
        wb_read(BASE + 32'h04, r);
        n_checks++;
        if (r !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL upper_bits: got %08h, required 0000ffff", r);
        end
        wb_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, lat);
        wb_read(BASE + 32'h40, r);
        n_checks++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL unmapped_read: got %08h, required 0", r);
        end
        wb_read(BASE + 32'h00, r);
        n_checks++;
        if (r !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL unmapped_write_ignored: OUT=%08h, required 000000ff", r);
        end
        // Address outside the decoded window must never be acked.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; dat_w = 32'h0; sel = 4'hF;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ack) seen++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (seen != 0 || gpio_out !== 16'h00FF) begin
            n_fail++;
            $display("FAIL foreign_addr: acks=%0d out=%h, required 0 acks out=00ff", seen, gpio_out);
        end
        $display("BUS addr=%08h foreign window acks=%0d", BASE + 32'h100, seen);
    endtask

    task automatic test_random_regs();
        int lat;
        logic [31:0] a, r;
        for (int it = 0; it < 40; it++) begin
            a = BASE + 32'($urandom_range(0, 15) * 4);
            wb_write(a, $urandom, 4'($urandom_range(0, 15)), lat);
            n_checks++;
            if (gpio_out !== m_out || gpio_oeb !== ~m_oe) begin
                n_fail++;
                $display("FAIL rand_pads it=%0d: out=%h oeb=%h, required %h %h", it, gpio_out, gpio_oeb, m_out, ~m_oe);
            end
        end
        for (int o = 0; o < 8; o++) begin
            a = BASE + 32'(o * 4);
            wb_read(a, r);
            n_checks++;
            if (r !== model_read(a)) begin
                n_fail++;
                $display("FAIL rand_read off=%0d: got %08h, required %08h", o * 4, r, model_read(a));
            end
        end
    endtask

    task automatic test_edge_irq();
        int lat;
        logic [31:0] r;
        wb_write(BASE + 32'h0C, 32'h0000_0020, 4'hF, lat);
        wb_write(BASE + 32'h10, 32'h0, 4'hF, lat);
        wb_write(BASE + 32'h14, 32'hFFFF, 4'hF, lat);
        gpio_in[5] = 1'b1;
        m_pins[5]  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 3'b000) begin
            n_fail++;
            $display("FAIL irq_early: irq=%b one edge after IN update, required 000", irq);
        end
        @(posedge clk); #1;
        n_checks++;
        if (irq !== 3'b100) begin
            n_fail++;
            $display("FAIL irq_rise5: irq=%b, required 100", irq);
        end
        m_stat = m_stat | 16'h0020;
        @(negedge clk);
        wb_read(BASE + 32'h08, r);
        n_checks++;
        if (r !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL in_read: got %08h, required 00000020", r);
        end
        wb_read(BASE + 32'h14, r);
        n_checks++;
        if (r !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL stat_rise5: got %08h, required 00000020", r);
        end
        wb_write(BASE + 32'h14, 32'h0000_0020, 4'hF, lat);
        n_checks++;
        if (irq !== 3'b000) begin
            n_fail++;
            $display("FAIL w1c_irq: irq=%b, required 000", irq);
        end
    endtask

    task automatic test_collision();
        int lat;
        logic [31:0] r;
        wb_write(BASE + 32'h0C, 32'h0, 4'hF, lat);
        wb_write(BASE + 32'h10, 32'h0000_0008, 4'hF, lat);
        gpio_in[3] = 1'b1; m_pins[3] = 1'b1;
        repeat (4) @(negedge clk);
        wb_write(BASE + 32'h14, 32'hFFFF, 4'hF, lat);
        gpio_in[3] = 1'b0; m_pins[3] = 1'b0;
        repeat (4) @(negedge clk);
        m_stat = m_stat | 16'h0008;
        n_checks++;
        if (irq !== 3'b001) begin
            n_fail++;
            $display("FAIL fall3_irq: irq=%b, required 001", irq);
        end
        gpio_in[3] = 1'b1; m_pins[3] = 1'b1;
        repeat (4) @(negedge clk);
        // Drop the pin so its fall event lands on the same edge as the W1C ack.
        gpio_in[3] = 1'b0; m_pins[3] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        wb_write(BASE + 32'h14, 32'h0000_0008, 4'hF, lat);
        m_stat = m_stat | 16'h0008;
        wb_read(BASE + 32'h14, r);
        n_checks++;
        if (r !== 32'h0000_0008 || irq !== 3'b001) begin
            n_fail++;
            $display("FAIL collision: STAT=%08h irq=%b, required 00000008 001", r, irq);
        end
        wb_write(BASE + 32'h14, 32'h0000_0008, 4'hF, lat);
        wb_read(BASE + 32'h14, r);
        n_checks++;
        if (r !== 32'd0 || irq !== 3'b000) begin
            n_fail++;
            $display("FAIL w1c_after_collision: STAT=%08h irq=%b, required 0 000", r, irq);
        end
    endtask

    task automatic test_random_edges();
        int lat;
        logic [31:0] r;
        logic [N-1:0] nv, ov;
        for (int it = 0; it < 20; it++) begin
            wb_write(BASE + 32'h0C, $urandom, 4'hF, lat);
            wb_write(BASE + 32'h10, $urandom, 4'hF, lat);
            n_checks++;
            if (irq !== model_irq()) begin
                n_fail++;
                $display("FAIL enable_no_event it=%0d: irq=%b, required %b", it, irq, model_irq());
            end
            ov = m_pins;
            nv = N'($urandom);
            gpio_in = nv;
            repeat (4) @(negedge clk);
            m_stat = m_stat | (nv & ~ov & m_rise) | (~nv & ov & m_fall);
            m_pins = nv;
            $display("PIN it=%0d pins %04h -> %04h stat_model=%04h", it, ov, nv, m_stat);
            n_checks++;
            if (irq !== model_irq()) begin
                n_fail++;
                $display("FAIL rand_irq it=%0d: irq=%b, required %b", it, irq, model_irq());
            end
            wb_read(BASE + 32'h14, r);
            n_checks++;
            if (r !== model_read(BASE + 32'h14)) begin
                n_fail++;
                $display("FAIL rand_stat it=%0d: got %08h, required %08h", it, r, model_read(BASE + 32'h14));
            end
            wb_read(BASE + 32'h08, r);
            n_checks++;
            if (r !== model_read(BASE + 32'h08)) begin
                n_fail++;
                $display("FAIL rand_in it=%0d: got %08h, required %08h", it, r, model_read(BASE + 32'h08));
            end
            if (it % 3 == 2) wb_write(BASE + 32'h14, $urandom, 4'($urandom_range(0, 15)), lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] r;
        wb_write(BASE + 32'h00, 32'hFFFF, 4'hF, lat);
        wb_write(BASE + 32'h04, 32'h00FF, 4'hF, lat);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h00; dat_w = 32'h1234; sel = 4'hF;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ack !== 1'b0 || gpio_out !== '0 || gpio_oeb !== '1 || irq !== 3'b000 || dat_r !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: ack=%b out=%h oeb=%h irq=%b dat=%h, required 0/0/ffff/000/0",
                     ack, gpio_out, gpio_oeb, irq, dat_r);
        end
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        model_reset();
        $display("RST asserted mid-write to OUT, released");
        repeat (3) @(negedge clk);
        wb_read(BASE + 32'h00, r);
        n_checks++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_no_partial_write: OUT=%08h, required 0", r);
        end
        wb_read(BASE + 32'h04, r);
        n_checks++;
        if (r !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_oe: OE=%08h, required 0", r);
        end
        wb_read(BASE + 32'h08, r);
        n_checks++;
        if (r !== model_read(BASE + 32'h08)) begin
            n_fail++;
            $display("FAIL reset_in_resync: IN=%08h, required %08h", r, model_read(BASE + 32'h08));
        end
    endtask

    initial begin
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
        gpio_in = '0;
        m_pins = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_set_clr();
        test_byte_enable();
        test_random_regs();
        test_edge_irq();
        test_collision();
        test_random_edges();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
